// File: rtl/uart_prog_loader.sv
// uart_prog_loader: boot-time program loader for the pipelined MIPS core.
// Receives an 8N1 UART frame of the form LEN_LO, LEN_HI, then LEN x 4 data bytes
// (little-endian words). Each word is written to instruction memory, and the core
// is held in reset until the last word has been written.
//
// Build option: define LOADER_CHECKSUM_EN to require a trailing XOR-of-data byte.
//
// Parameters:
//   CLKS_PER_BIT - clk cycles per UART bit (minimum 4)
//   MAX_WORDS    - instruction memory depth in words
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   rx         - UART line, idle high, asynchronous to clk
//   imem_we    - one-cycle write strobe to instruction memory
//   imem_addr  - byte address of the write ({word index, 2'b00})
//   imem_wdata - assembled 32-bit word
//   cpu_reset  - core reset, high until the image is loaded
//   load_done  - sticky: image written successfully
//   load_err   - sticky: framing, length or checksum error
module uart_prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        load_err
);

    localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

    // ------------------------------------------------------------------
    // RX synchronizer
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // RX FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    rx_state_e       rx_state_q, rx_state_d;
    logic [CntW-1:0] clk_cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      rx_shift_q;
    logic            byte_valid, frame_bad;

    always_ff @(posedge clk) begin
        if (reset) rx_state_q <= RxIdle;
        else       rx_state_q <= rx_state_d;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RxIdle:  if (!rx_sync) rx_state_d = RxStart;
            // Mid-start-bit re-check rejects glitches shorter than half a bit.
            RxStart: if (clk_cnt_q == CntHalf) rx_state_d = rx_sync ? RxIdle : RxData;
            RxData:  if (clk_cnt_q == CntFull && bit_cnt_q == 3'd7) rx_state_d = RxStop;
            RxStop:  if (clk_cnt_q == CntFull) rx_state_d = RxIdle;
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        byte_valid = 1'b0;
        frame_bad  = 1'b0;
        if (rx_state_q == RxStop && clk_cnt_q == CntFull) begin
            byte_valid = rx_sync;
            frame_bad  = ~rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
        end else begin
            unique case (rx_state_q)
                RxIdle:  clk_cnt_q <= '0;
                RxStart: clk_cnt_q <= (clk_cnt_q == CntHalf) ? '0 : clk_cnt_q + CntW'(1);
                RxData: begin
                    if (clk_cnt_q == CntFull) begin
                        clk_cnt_q  <= '0;
                        rx_shift_q <= {rx_sync, rx_shift_q[7:1]};  // LSB first
                        bit_cnt_q  <= bit_cnt_q + 3'd1;
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CntW'(1);
                    end
                end
                RxStop:  clk_cnt_q <= (clk_cnt_q == CntFull) ? '0 : clk_cnt_q + CntW'(1);
                default: clk_cnt_q <= '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        LdLenLo, LdLenHi, LdData, LdWrite, LdDone, LdErr
`ifdef LOADER_CHECKSUM_EN
        , LdCsum
`endif
    } ld_state_e;

`ifdef LOADER_CHECKSUM_EN
    localparam ld_state_e LdTail = LdCsum;
`else
    localparam ld_state_e LdTail = LdDone;
`endif

    ld_state_e   ld_state_q, ld_state_d;
    logic [7:0]  len_lo_q;
    logic [15:0] len_q;
    logic [15:0] word_idx_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] word_q;
    logic [15:0] len_rx;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign len_rx = {rx_shift_q, len_lo_q};

    always_ff @(posedge clk) begin
        if (reset) ld_state_q <= LdLenLo;
        else       ld_state_q <= ld_state_d;
    end

    always_comb begin
        ld_state_d = ld_state_q;
        unique case (ld_state_q)
            LdLenLo: if (byte_valid) ld_state_d = LdLenHi;
            LdLenHi: begin
                if (byte_valid) begin
                    if (len_rx == 16'd0)                ld_state_d = LdTail;
                    else if (32'(len_rx) > MAX_WORDS)   ld_state_d = LdErr;
                    else                                ld_state_d = LdData;
                end
            end
            LdData:  if (byte_valid && byte_cnt_q == 2'd3) ld_state_d = LdWrite;
            LdWrite: ld_state_d = (word_idx_q + 16'd1 == len_q) ? LdTail : LdData;
`ifdef LOADER_CHECKSUM_EN
            LdCsum:  if (byte_valid) ld_state_d = (rx_shift_q == csum_q) ? LdDone : LdErr;
`endif
            LdDone:  ld_state_d = LdDone;
            LdErr:   ld_state_d = LdErr;
            default: ld_state_d = LdErr;
        endcase
        // A finished load is immune to later line noise.
        if (frame_bad && ld_state_q != LdDone) ld_state_d = LdErr;
    end

    always_comb begin
        imem_we    = (ld_state_q == LdWrite);
        cpu_reset  = (ld_state_q != LdDone);
        load_done  = (ld_state_q == LdDone);
        load_err   = (ld_state_q == LdErr);
        imem_addr  = {14'd0, word_idx_q, 2'b00};
        imem_wdata = word_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_lo_q   <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            if (ld_state_q == LdLenLo && byte_valid) len_lo_q <= rx_shift_q;
            if (ld_state_q == LdLenHi && byte_valid) len_q    <= len_rx;
            if (ld_state_q == LdData && byte_valid) begin
                word_q     <= {rx_shift_q, word_q[31:8]};  // first byte ends in [7:0]
                byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ rx_shift_q;
`endif
            end
            if (ld_state_q == LdWrite) word_idx_q <= word_idx_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader with CLKS_PER_BIT = 8.
module tb_uart_prog_loader;

    localparam int Cpb = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        imem_we;
    logic [31:0] imem_addr, imem_wdata;
    logic        cpu_reset, load_done, load_err;

    uart_prog_loader #(.CLKS_PER_BIT(Cpb), .MAX_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor, sampled on the falling edge.
    int          wr_cnt = 0;
    int          we_cyc = 0;
    int          fall_cyc = 0;
    logic        prev_we = 1'b0;
    logic        prev_cr = 1'b1;
    logic        dbl = 1'b0;
    logic [31:0] cap_a [4];
    logic [31:0] cap_d [4];

    always @(negedge clk) begin
        if (reset) begin
            wr_cnt   <= 0;
            we_cyc   <= 0;
            fall_cyc <= 0;
            prev_we  <= 1'b0;
            prev_cr  <= 1'b1;
            dbl      <= 1'b0;
        end else begin
            if (imem_we) begin
                if (wr_cnt < 4) begin
                    cap_a[wr_cnt] <= imem_addr;
                    cap_d[wr_cnt] <= imem_wdata;
                end
                wr_cnt <= wr_cnt + 1;
                we_cyc <= cyc;
                if (prev_we) dbl <= 1'b1;
            end
            if (prev_cr && !cpu_reset) fall_cyc <= cyc;
            prev_we <= imem_we;
            prev_cr <= cpu_reset;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Starts and ends on a falling edge, so consecutive calls are back-to-back.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (Cpb) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (Cpb) @(negedge clk);
        end
        rx = stop;
        repeat (Cpb) @(negedge clk);
        if (!stop) begin
            rx = 1'b1;
            repeat (2 * Cpb) @(negedge clk);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [0:13][7:0] b;
        int               n;
        int               bad_at;     // byte sent with stop bit 0, -1 for none
        int               rst_after;  // reset after this byte, -1 for none
        bit               add_csum;   // append XOR byte in checksum builds
        int               exp_wr;
        logic [31:0]      d0;
        logic [31:0]      d1;
        bit               done;
        bit               err;
    } vec_t;

    function automatic vec_t mk(input logic [111:0] b, input int n, input int bad_at,
                                input int rst_after, input bit add_csum, input int exp_wr,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input bit done, input bit err);
        vec_t v;
        v.b = b; v.n = n; v.bad_at = bad_at; v.rst_after = rst_after;
        v.add_csum = add_csum; v.exp_wr = exp_wr; v.d0 = d0; v.d1 = d1;
        v.done = done; v.err = err;
        return v;
    endfunction

    task automatic check_result(input string tag, input int exp_wr, input logic [31:0] d0,
                                input logic [31:0] d1, input bit done, input bit err);
        chk({tag, "_wr_count"}, 32'(wr_cnt), 32'(exp_wr));
        if (exp_wr >= 1) begin
            chk({tag, "_addr0"}, cap_a[0], 32'h0);
            chk({tag, "_data0"}, cap_d[0], d0);
        end
        if (exp_wr >= 2) begin
            chk({tag, "_addr1"}, cap_a[1], 32'h4);
            chk({tag, "_data1"}, cap_d[1], d1);
        end
        chk({tag, "_load_done"}, 32'(load_done), 32'(done));
        chk({tag, "_load_err"}, 32'(load_err), 32'(err));
        chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!done));
        chk({tag, "_we_single_cycle"}, 32'(dbl), 32'h0);
`ifndef LOADER_CHECKSUM_EN
        if (done && exp_wr > 0)
            chk({tag, "_release_delay"}, 32'(fall_cyc - we_cyc), 32'd1);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] cs = 8'h00;
        int         fs = 0;
`endif
        do_reset();
        for (int k = 0; k < v.n; k++) begin
            send_byte(v.b[k], k != v.bad_at);
`ifdef LOADER_CHECKSUM_EN
            if (k >= fs + 2) cs ^= v.b[k];
`endif
            if (k == v.rst_after) begin
                do_reset();
`ifdef LOADER_CHECKSUM_EN
                fs = k + 1;
                cs = 8'h00;
`endif
            end
        end
`ifdef LOADER_CHECKSUM_EN
        if (v.add_csum) send_byte(cs, 1'b1);
`endif
        repeat (40) @(negedge clk);
        check_result($sformatf("vec%0d", idx), v.exp_wr, v.d0, v.d1, v.done, v.err);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk({8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                          8'h00, 8'h00, 8'h00, 8'h00}, 10, -1, -1, 1'b1, 2,
                         32'h12345678, 32'hDEADBEEF, 1'b1, 1'b0));
        tbl.push_back(mk({8'h01, 8'h04, 96'h0}, 2, -1, -1, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk({8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 48'h0},
                         8, 3, -1, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1));
        tbl.push_back(mk({8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                          8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00}, 13, -1, 6, 1'b1, 1,
                         32'hDDCCBBAA, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk({8'h00, 8'h00, 96'h0}, 2, -1, -1, 1'b1, 0, 32'h0, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk({8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 64'h0}, 6, -1, -1, 1'b1, 1,
                         32'h04030201, 32'h0, 1'b1, 1'b0));
`ifdef LOADER_CHECKSUM_EN
        tbl.push_back(mk({8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F, 56'h0}, 7, -1, -1,
                         1'b0, 1, 32'h08040201, 32'h0, 1'b1, 1'b0));
        tbl.push_back(mk({8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E, 56'h0}, 7, -1, -1,
                         1'b0, 1, 32'h08040201, 32'h0, 1'b0, 1'b1));
`endif

        // Reset state, observed while reset is still held.
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_imem_we", 32'(imem_we), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_imem_wdata", imem_wdata, 32'h0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("rst_load_done", 32'(load_done), 32'h0);
        chk("rst_load_err", 32'(load_err), 32'h0);
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i], i);

        // False start: a 2-cycle glitch must not disturb the following frame.
        do_reset();
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (5 * Cpb) @(negedge clk);
        chk("glitch_wr_count", 32'(wr_cnt), 32'h0);
        chk("glitch_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("glitch_load_err", 32'(load_err), 32'h0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hDE, 1'b1);
        send_byte(8'hC0, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'h0B, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hDE ^ 8'hC0 ^ 8'hAD ^ 8'h0B, 1'b1);
`endif
        repeat (40) @(negedge clk);
        check_result("glitch_then_frame", 1, 32'h0BADC0DE, 32'h0, 1'b1, 1'b0);

        // Line stuck low: periodic framing errors force the error state.
        do_reset();
        rx = 1'b0;
        repeat (25 * Cpb) @(negedge clk);
        chk("stuck_low_load_err", 32'(load_err), 32'h1);
        chk("stuck_low_cpu_reset", 32'(cpu_reset), 32'h1);
        chk("stuck_low_load_done", 32'(load_done), 32'h0);
        chk("stuck_low_wr_count", 32'(wr_cnt), 32'h0);
        rx = 1'b1;
        repeat (4) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
